// File: rtl/fwd_hazard_unit_pkg.sv
// rtl/fwd_hazard_unit_pkg.sv - shared types and constants for the forwarding/hazard unit
package fwd_hazard_unit_pkg;

  localparam int DEF_AW    = 5;
  localparam int DEF_DEPTH = 3;
  localparam int DEF_LAT_W = 2;

  typedef logic [DEF_LAT_W-1:0] lat_t;

  localparam lat_t LAT_ALU  = lat_t'(1);
  localparam lat_t LAT_LOAD = lat_t'(2);

  typedef struct packed {
    logic              v;
    logic [DEF_AW-1:0] rd;
    logic              we;
    lat_t              cnt;
  } fwd_entry_t;

endpackage

// File: rtl/fwd_match.sv
// rtl/fwd_match.sv - youngest-producer match finder for one source operand
module fwd_match
  import fwd_hazard_unit_pkg::*;
#(
  parameter int AW    = DEF_AW,
  parameter int N     = DEF_DEPTH - 1,
  parameter int SEL_W = 2
) (
  input  logic [AW-1:0]    rs,
  input  fwd_entry_t       ent [N],
  output logic             hit,
  output logic [SEL_W-1:0] sel,
  output logic             late
);

  // Scan oldest to youngest so the youngest hit overwrites older ones.
  always_comb begin
    hit  = 1'b0;
    sel  = '0;
    late = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (ent[k].v && ent[k].we && (ent[k].rd != '0) && (ent[k].rd == rs)) begin
        hit  = 1'b1;
        sel  = SEL_W'(k + 1);
        late = (ent[k].cnt > lat_t'(1));
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand forwarding select and load-use stall generation
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter  int AW      = DEF_AW,
  parameter  int NUM_SRC = 2,
  parameter  int DEPTH   = DEF_DEPTH,
  parameter  int LAT_W   = DEF_LAT_W,
  localparam int SEL_W   = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [NUM_SRC*AW-1:0]    id_rs,
  input  logic [AW-1:0]            id_rd,
  input  logic                     id_regwrite,
  input  logic [LAT_W-1:0]         id_lat,
  input  logic                     flush,
  output logic                     stall,
  output logic [NUM_SRC-1:0]       ex_fwd_en,
  output logic [NUM_SRC*SEL_W-1:0] ex_fwd_sel,
  output logic [15:0]              stall_cnt
);

  // The WB position is not kept: its producer counts as already written.
  localparam int NSTORE = DEPTH - 1;

  fwd_entry_t               pipe_q [NSTORE];
  fwd_entry_t               pipe_d [NSTORE];
  logic [NUM_SRC-1:0]       fwd_en_q, fwd_en_d;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel_q, fwd_sel_d;
  logic [15:0]              stall_cnt_q, stall_cnt_d;

  logic [NUM_SRC-1:0]       hit;
  logic [NUM_SRC-1:0]       late;
  logic [SEL_W-1:0]         sel_w [NUM_SRC];
  logic                     live;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    fwd_match #(
      .AW   (AW),
      .N    (NSTORE),
      .SEL_W(SEL_W)
    ) u_match (
      .rs  (id_rs[s*AW +: AW]),
      .ent (pipe_q),
      .hit (hit[s]),
      .sel (sel_w[s]),
      .late(late[s])
    );
  end

  always_comb begin
    live  = id_valid & ~flush;
    stall = live & (|late) & ~rst;

    pipe_d[0].v   = live & ~stall;
    pipe_d[0].rd  = id_rd;
    pipe_d[0].we  = id_regwrite;
    pipe_d[0].cnt = (id_lat == '0) ? lat_t'(1) : id_lat;
    for (int k = 1; k < NSTORE; k++) begin
      pipe_d[k] = pipe_q[k-1];
      if (pipe_q[k-1].cnt != '0) pipe_d[k].cnt = pipe_q[k-1].cnt - lat_t'(1);
    end

    // A stalled or flushed ID sends a bubble to EX, so nothing is forwarded.
    fwd_en_d  = '0;
    fwd_sel_d = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (live && !stall && hit[s]) begin
        fwd_en_d[s]                 = 1'b1;
        fwd_sel_d[s*SEL_W +: SEL_W] = sel_w[s];
      end
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NSTORE; k++) pipe_q[k] <= '0;
      fwd_en_q    <= '0;
      fwd_sel_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int k = 0; k < NSTORE; k++) pipe_q[k] <= pipe_d[k];
      fwd_en_q    <= fwd_en_d;
      fwd_sel_q   <= fwd_sel_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_fwd_en  = fwd_en_q;
  assign ex_fwd_sel = fwd_sel_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter AW, default 5: register-address width.
REQ-002 Parameter NUM_SRC, default 2: source operands per instruction.
REQ-003 Parameter DEPTH, default 3: tracked stages; position 0=EX, 1=MEM, ..., DEPTH-1=WB.
REQ-004 Parameter LAT_W, default 2: latency-field width; SEL_W = clog2(DEPTH), derived.
REQ-005 clk  in  1  sole clock; one clock domain; all state updates on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 id_valid  in  1  ID holds a real instruction.
REQ-008 id_rs  in  NUM_SRC*AW  source register addresses; operand s in bits [s*AW +: AW].
REQ-009 id_rd  in  AW  destination register address.
REQ-010 id_regwrite  in  1  instruction writes id_rd.
REQ-011 id_lat  in  LAT_W  cycles after entering EX until the result is forwardable; ALU=1, load=2.
REQ-012 flush  in  1  kill the ID instruction.
REQ-013 stall  out  1  hold PC/IF/ID and insert an EX bubble this cycle.
REQ-014 ex_fwd_en  out  NUM_SRC  forward operand s to the EX instruction.
REQ-015 ex_fwd_sel  out  NUM_SRC*SEL_W  forwarding source position (1..DEPTH-1) for each enabled operand.
REQ-016 stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-017 Each tracked entry p[k], k=0..DEPTH-1, SHALL hold {v, rd, we, cnt[LAT_W]}.
REQ-018 Each cycle, p[k] <= p[k-1] for k>=1, with cnt decremented and saturating at 0; p[DEPTH-1] is discarded.
REQ-019 p[0] <= {id_valid & ~flush & ~stall, id_rd, id_regwrite, max(id_lat,1)}; otherwise p[0] becomes a bubble (v=0).
REQ-020 Match for source s: entry k in 0..DEPTH-2 with v=1, we=1, rd!=0 and rd==id_rs[s]; the youngest entry (lowest k) SHALL win.
REQ-021 stall SHALL be combinational: 1 when id_valid & ~flush and any source's winning match has cnt>1; else 0.
REQ-022 When no stall occurs, ex_fwd_en[s] <= match found and ex_fwd_sel[s] <= k+1 of the winning match; no match gives en=0, sel=0.
REQ-023 During stall or flush, ex_fwd_en and ex_fwd_sel SHALL load 0, matching the bubble.
REQ-024 Forwarding outputs SHALL be registered: latency exactly 1 cycle from ID decision to EX use.
REQ-025 Register 0 SHALL never match, stall or forward.
REQ-026 A producer older than position DEPTH-1 SHALL be treated as written to the register file (write-before-read); no forwarding.
REQ-027 Simultaneous stall condition and flush: flush SHALL win; stall=0 and a bubble enters EX.
REQ-028 stall_cnt SHALL increment on each cycle with stall=1 and hold at 16'hFFFF.
REQ-029 A multi-cycle producer (cnt>1) SHALL hold stall for exactly cnt-1 consecutive cycles before the consumer advances.

Reset
REQ-030 With rst=1 at an edge, all p[k].v, ex_fwd_en, ex_fwd_sel and stall_cnt SHALL become 0.
REQ-031 During reset, stall SHALL read 0, because no valid entries exist.
REQ-032 Reset mid-stall SHALL abandon in-flight entries; the cycle after deassertion behaves as empty.

Structure
REQ-033 A shared package SHALL hold the entry struct, default AW/DEPTH/LAT_W and latency constants LAT_ALU=1 and LAT_LOAD=2.
REQ-034 One sub-module, fwd_match, SHALL implement the per-source youngest-match priority finder.
REQ-035 fwd_hazard_unit SHALL instantiate NUM_SRC copies of fwd_match.

Verification
REQ-036 ALU producer rd=5, lat=1, followed by consumer rs0=5: stall=0; next cycle ex_fwd_en[0]=1, sel=1.
REQ-037 Load rd=7, lat=2, followed by consumer rs1=7: stall=1 for one cycle, stall_cnt=1, then ex_fwd_en[1]=1, sel=2.
REQ-038 Two producers rd=3 (older ALU, then younger ALU), then consumer rs0=3: sel=1, so the youngest wins; with a gap instruction between, sel=2.
REQ-039 Producer rd=0, regwrite=1, then consumer rs0=0: stall=0 and ex_fwd_en=0.
REQ-040 Load-use with flush=1 in the stalling cycle: stall=0, bubble in EX, ex_fwd_en=0; reset mid-stall clears stall_cnt to 0.
